// File: rtl/silly_function_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : silly_function_pkg
//  Purpose  : Shared types and the truth table for the silly_function block.
//             Bit i of SILLY_TT is the function value for minterm i = {a,b,c}.
//  Contents : minterm_t, SILLY_TT, tt_lookup()
//  Revision : 1.0 - initial release
// ============================================================================
package silly_function_pkg;

    typedef logic [2:0] minterm_t;

    // Minterms 0, 4 and 5 are true; equivalent to ~b & (a | ~c).
    localparam logic [7:0] SILLY_TT = 8'b0011_0001;

    // Indexing with an X/Z minterm yields X in simulation, so unknown
    // inputs propagate to the output rather than being masked.
    function automatic logic tt_lookup(input minterm_t m);
        return SILLY_TT[m];
    endfunction

endpackage
`default_nettype wire

// File: rtl/silly_function_cov.sv
`default_nettype none
// ============================================================================
//  Module   : silly_function_cov
//  Purpose  : Bank of eight saturating minterm occurrence counters.
//             Every non-reset edge bumps the counter selected by idx_i,
//             unless cov_clr_i is high, in which case all counters clear.
//  Ports    : clk, reset    - clock, synchronous active-high reset
//             idx_i         - minterm sampled this edge
//             cov_sel_i     - counter read select
//             cov_clr_i     - synchronous clear of all counters
//             cov_cnt_o     - counter[cov_sel_i], combinational read
//  Params   : CNT_W         - counter width (>= 1)
//  Revision : 1.0 - initial release
// ============================================================================
module silly_function_cov
    import silly_function_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  minterm_t         idx_i,
    input  logic [2:0]       cov_sel_i,
    input  logic             cov_clr_i,
    output logic [CNT_W-1:0] cov_cnt_o
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];

    for (genvar i = 0; i < 8; i++) begin : g_cnt
        always_comb begin
            cnt_d[i] = cnt_q[i];
            if (cov_clr_i) begin
                cnt_d[i] = '0;
            end else if ((idx_i == minterm_t'(i)) && (cnt_q[i] != '1)) begin
                // Hold at all-ones instead of wrapping.
                cnt_d[i] = cnt_q[i] + C_ONE;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cov_cnt_o = cnt_q[cov_sel_i];

endmodule
`default_nettype wire

// File: rtl/silly_function.sv
`default_nettype none
// ============================================================================
//  Module   : silly_function
//  Purpose  : y = ~b & (a | ~c), as a combinational output and a registered
//             copy alongside the registered minterm index {a,b,c}.
//             Optional per-minterm occurrence counters are built when the
//             macro SILLY_FUNCTION_COV_EN is defined; otherwise cov_cnt is 0
//             and cov_sel/cov_clr are ignored. Port list is identical.
//  Ports    : clk, reset    - clock, synchronous active-high reset
//             a, b, c       - function inputs (a = MSB of minterm index)
//             y             - combinational function output
//             y_q, idx_q    - registered y and {a,b,c}, 1-cycle latency
//             cov_sel       - counter read select
//             cov_clr       - synchronous clear of all counters
//             cov_cnt       - occurrence count of minterm cov_sel
//  Params   : CNT_W         - counter width (>= 1)
//  Revision : 1.0 - initial release
// ============================================================================
module silly_function
    import silly_function_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             y,
    output logic             y_q,
    output logic [2:0]       idx_q,
    input  logic [2:0]       cov_sel,
    input  logic             cov_clr,
    output logic [CNT_W-1:0] cov_cnt
);

    minterm_t idx_d;

    assign idx_d = {a, b, c};
    assign y     = tt_lookup(idx_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q   <= 1'b0;
            idx_q <= 3'b000;
        end else begin
            y_q   <= y;
            idx_q <= idx_d;
        end
    end

`ifdef SILLY_FUNCTION_COV_EN
    silly_function_cov #(
        .CNT_W (CNT_W)
    ) u_cov (
        .clk       (clk),
        .reset     (reset),
        .idx_i     (idx_d),
        .cov_sel_i (cov_sel),
        .cov_clr_i (cov_clr),
        .cov_cnt_o (cov_cnt)
    );
`else
    // Coverage controls have no effect in this build.
    logic w_unused_cov;
    assign w_unused_cov = ^{cov_sel, cov_clr};
    assign cov_cnt      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_silly_function.sv
`default_nettype none
// ============================================================================
//  Module   : tb_silly_function
//  Purpose  : Self-checking bench for silly_function. Two instances: the
//             default CNT_W=16 and a CNT_W=2 copy for counter saturation.
//             Expectations for coverage depend on SILLY_FUNCTION_COV_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
module tb_silly_function;

    localparam int CNT_W_A = 16;
    localparam int CNT_W_B = 2;

`ifdef SILLY_FUNCTION_COV_EN
    localparam bit COV_ON = 1'b1;
`else
    localparam bit COV_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, a, b, c, cov_clr;
    logic [2:0] cov_sel;
    logic y_a, yq_a, y_b, yq_b;
    logic [2:0] idx_a, idx_b;
    logic [CNT_W_A-1:0] cnt_a;
    logic [CNT_W_B-1:0] cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    silly_function #(.CNT_W(CNT_W_A)) dut_a (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
        .y(y_a), .y_q(yq_a), .idx_q(idx_a),
        .cov_sel(cov_sel), .cov_clr(cov_clr), .cov_cnt(cnt_a)
    );

    silly_function #(.CNT_W(CNT_W_B)) dut_b (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
        .y(y_b), .y_q(yq_b), .idx_q(idx_b),
        .cov_sel(cov_sel), .cov_clr(cov_clr), .cov_cnt(cnt_b)
    );

    // ---------------- behavioural model ----------------
    function automatic logic f_model(input logic ma, input logic mb, input logic mc);
        return ~mb & (ma | ~mc);
    endfunction

    bit   m_valid = 1'b0;
    logic m_yq;
    int   m_idx;
    int   m_cnt_a [8];
    int   m_cnt_b [8];

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_yq    = 1'b0;
            m_idx   = 0;
            foreach (m_cnt_a[i]) begin
                m_cnt_a[i] = 0;
                m_cnt_b[i] = 0;
            end
        end else begin
            m_yq  = f_model(a, b, c);
            m_idx = int'({a, b, c});
            if (cov_clr) begin
                foreach (m_cnt_a[i]) begin
                    m_cnt_a[i] = 0;
                    m_cnt_b[i] = 0;
                end
            end else begin
                if (m_cnt_a[m_idx] < (2**CNT_W_A - 1)) m_cnt_a[m_idx]++;
                if (m_cnt_b[m_idx] < (2**CNT_W_B - 1)) m_cnt_b[m_idx]++;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_cov_a(input int sel);
        return COV_ON ? m_cnt_a[sel] : 0;
    endfunction

    function automatic int exp_cov_b(input int sel);
        return COV_ON ? m_cnt_b[sel] : 0;
    endfunction

    task automatic cycle_compare();
        chk("y_a", {31'd0, y_a}, {31'd0, f_model(a, b, c)});
        chk("y_b", {31'd0, y_b}, {31'd0, f_model(a, b, c)});
        if (m_valid) begin
            chk("y_q", {31'd0, yq_a}, {31'd0, m_yq});
            chk("idx_q", {29'd0, idx_a}, m_idx);
            chk("y_q_b", {31'd0, yq_b}, {31'd0, m_yq});
            chk("cov_cnt_a", {16'd0, cnt_a}, exp_cov_a(int'(cov_sel)));
            chk("cov_cnt_b", {30'd0, cnt_b}, exp_cov_b(int'(cov_sel)));
        end
    endtask

    // Compare at the falling edge, then land 2 units after the next rising edge.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cycle_compare();
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_abc(input logic [2:0] v);
        {a, b, c} = v;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int exp_y [8];
        int cov_exp_lit [8];
        logic [2:0] v;
        exp_y = '{1, 0, 0, 0, 1, 1, 0, 0};

        reset   = 1'b1;
        cov_clr = 1'b0;
        cov_sel = 3'd0;
        set_abc(3'b000);

        // 1. exhaustive sweep of the combinational output
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            set_abc(v);
            #1;
            chk("sweep_y_lit", {31'd0, y_a}, exp_y[i]);
            chk("sweep_y_min", {31'd0, y_a}, {31'd0, ~b & (a | ~c)});
            #9;
        end
        @(posedge clk);
        #2;

        // 2. registered path across reset release
        set_abc(3'b101);
        step(2);
        chk("rst_y_q", {31'd0, yq_a}, 32'd0);
        chk("rst_idx_q", {29'd0, idx_a}, 32'd0);
        reset = 1'b0;
        step(1);
        chk("post_rst_y_q", {31'd0, yq_a}, 32'd1);
        chk("post_rst_idx_q", {29'd0, idx_a}, 32'd5);

        // 3. reset mid-stream
        set_abc(3'b100);
        step(1);
        chk("mid_y_q_before", {31'd0, yq_a}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_y_during", {31'd0, y_a}, 32'd1);
        step(1);
        chk("mid_y_q_after", {31'd0, yq_a}, 32'd0);
        chk("mid_y_after", {31'd0, y_a}, 32'd1);
        reset = 1'b0;

        // 4. coverage counts (literal zeros when the feature is not built)
        cov_clr = 1'b1;
        set_abc(3'b000);
        step(1);
        cov_clr = 1'b0;
        step(3);
        set_abc(3'b111);
        step(2);
        cov_exp_lit = '{3, 0, 0, 0, 0, 0, 0, 2};
        for (int s = 0; s < 8; s++) begin
            cov_sel = 3'(s);
            #1;
            chk("cov_lit", {16'd0, cnt_a}, COV_ON ? cov_exp_lit[s] : 0);
        end
        cov_clr = 1'b1;
        step(1);
        cov_clr = 1'b0;
        for (int s = 0; s < 8; s++) begin
            cov_sel = 3'(s);
            #1;
            chk("cov_clr_lit", {16'd0, cnt_a}, 32'd0);
        end

        // 5. saturation on the narrow instance
        cov_clr = 1'b1;
        step(1);
        cov_clr = 1'b0;
        set_abc(3'b100);
        step(5);
        cov_sel = 3'd4;
        #1;
        chk("sat_cnt_b", {30'd0, cnt_b}, COV_ON ? 32'd3 : 32'd0);
        chk("wide_cnt_a", {16'd0, cnt_a}, COV_ON ? 32'd5 : 32'd0);

        // a few more model-checked cycles over all minterms
        for (int i = 0; i < 8; i++) begin
            set_abc(3'(7 - i));
            cov_sel = 3'(i);
            step(1);
        end
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
